// File: rtl/sram_ctrl.sv
// Single-port SRAM controller: valid/ready requests, byte-masked writes, pipelined reads
// with configurable latency, and a clear engine that runs after reset and on request.
module sram_ctrl #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       DEPTH     = 16,
  parameter int unsigned       RD_LAT    = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_req_valid,
  output logic                         io_req_ready,
  input  logic                         io_req_we,
  input  logic [$clog2(DEPTH)-1:0]     io_req_addr,
  input  logic [DATA_W-1:0]            io_req_wdata,
  input  logic [DATA_W/8-1:0]          io_req_wmask,
  output logic                         io_resp_valid,
  output logic [DATA_W-1:0]            io_resp_data,
  input  logic                         io_clear,
  output logic                         io_init_done
);

  localparam int unsigned       ADDR_W   = $clog2(DEPTH);
  localparam int unsigned       NumBytes = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                ready_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [RD_LAT-1:0]   vld_q;
  logic [DATA_W-1:0]   data_q [RD_LAT];

  logic                req_acc;
  logic                in_range;
  logic [DATA_W-1:0]   rd_word;

  assign req_acc = io_req_valid && ready_q;

  // Only a non-power-of-two depth can see addresses past the end of the array.
  if (DEPTH == (2 ** ADDR_W)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (32'(io_req_addr) < DEPTH);
  end

  assign rd_word = in_range ? mem[io_req_addr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StClear;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastAddr) begin
            state_q <= StReady;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StReady: begin
          if (io_clear) begin
            state_q <= StClear;
            ready_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  // The array has no reset; the clear engine owns it whenever the FSM is in StClear.
  always_ff @(posedge clock) begin
    if (state_q == StClear) begin
      mem[cnt_q] <= CLEAR_VAL;
    end else if (req_acc && io_req_we && in_range) begin
      for (int b = 0; b < int'(NumBytes); b++) begin
        if (io_req_wmask[b]) begin
          mem[io_req_addr][8*b +: 8] <= io_req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Data only moves with its valid bit, so the last stage holds its value between responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= req_acc && !io_req_we;
      if (req_acc && !io_req_we) begin
        data_q[0] <= rd_word;
      end
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign io_req_ready  = ready_q;
  assign io_init_done  = ready_q;
  assign io_resp_valid = vld_q[RD_LAT-1];
  assign io_resp_data  = data_q[RD_LAT-1];

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Parametrised single-port SRAM with a valid/ready request interface, per-byte write mask, configurable read latency, and a hardware clear engine. After reset, and on request, it clears every word to CLEAR_VAL. It is the next-generation SRAM core: clients issue one request per cycle and receive read data through a pipelined response channel.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8, minimum 8.
DEPTH, 16, number of words; minimum 2; need not be a power of two.
RD_LAT, 1, cycles from an accepted read to io_resp_valid; minimum 1.
CLEAR_VAL, 0, value written to every word by the clear engine (DATA_W bits).
ADDR_W (localparam), clog2(DEPTH), address width.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
io_req_valid  in  1  request present.
io_req_ready  out  1  controller accepts a request this cycle.
io_req_we  in  1  1 = write, 0 = read.
io_req_addr  in  ADDR_W  word address.
io_req_wdata  in  DATA_W  write data.
io_req_wmask  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i].
io_resp_valid  out  1  read data valid, one-cycle pulse per read.
io_resp_data  out  DATA_W  read data.
io_clear  in  1  pulse to start a full clear.
io_init_done  out  1  high while the controller is in READY.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM goes to CLEAR with the clear counter at 0.
  - All read-pipeline valid bits are cleared.
  - Outputs: io_req_ready=0, io_resp_valid=0, io_resp_data=0, io_init_done=0.
- FSM has two states, CLEAR and READY.
- CLEAR:
  - Writes CLEAR_VAL to address cnt each cycle, then increments cnt.
  - After writing DEPTH-1, moves to READY on the next edge.
  - After reset release, CLEAR takes exactly DEPTH cycles.
  - io_req_ready=0 and io_init_done=0 throughout; io_clear is ignored.
- READY:
  - io_req_ready=1 and io_init_done=1.
  - io_clear=1 moves the FSM to CLEAR with cnt=0. A request in that same cycle is still accepted (ready is already high). Reads already in the pipeline drain normally, with their data captured at acceptance.
- A request is accepted when io_req_valid && io_req_ready.
- Accepted write:
  - Updates each byte whose mask bit is 1 at that edge; bytes with mask 0 are unchanged.
  - Mask all-zero is a legal no-op.
  - No response is produced.
- Accepted read:
  - The array is sampled at the acceptance edge.
  - io_resp_valid=1 and io_resp_data=word exactly RD_LAT cycles after acceptance, as a pulse lasting one cycle.
  - Back-to-back reads give back-to-back responses, in order.
  - There is no backpressure on the response channel.
- io_resp_data holds its last value when io_resp_valid=0.
- Read-after-write:
  - A read accepted the cycle after a write to the same address returns the new data.
  - A write accepted after a read does not affect that read's data.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH is not a power of two): writes are dropped, reads return 0 with normal timing.
- Reset mid-operation: in-flight reads are discarded (no io_resp_valid) and a full clear restarts.
- Memory contents are undefined only between reset assertion and completion of the clear.

Test Plan:
1. DATA_W=16, DEPTH=16, RD_LAT=2: release reset -> io_req_ready=0 for 16 cycles, then io_init_done=1; reading addr 5 returns 0x0000.
2. Write 0x1234 to addr 0 and 0xABCD to addr 1 (mask 2'b11), then read 0 then read 1 back-to-back -> io_resp_valid high in two consecutive cycles, 2 cycles after each read, with data 0x1234 then 0xABCD.
3. Write 0xABCD to addr 3, then write 0x5566 to addr 3 with mask 2'b01, then read 3 -> 0xAB66.
4. Write 0x00FF to addr 7, then the next cycle read 7 and the cycle after write 0x1111 to addr 7 -> response 0x00FF; a subsequent read of 7 returns 0x1111.
5. Read addr 1 (holding 0xABCD) and pulse io_clear in the same cycle -> response 0xABCD after 2 cycles; io_req_ready=0 for 16 cycles; reading addr 1 afterwards returns 0x0000.
6. Issue a read, then assert reset one cycle later -> no io_resp_valid pulse; all outputs 0 immediately; the clear restarts and takes 16 cycles after reset release.
